seq_reduce_gate: RTL and testbench
==================================

Name: seq_reduce_gate

Overview:
- Parametrised, sequential successor to the fixed 4-input AND tree.
- Accepts DEPTH operand words of WIDTH bits over a valid/ready stream and folds them bitwise with a selectable operator (AND/OR/XOR/NAND).
- Presents the WIDTH-bit folded word plus a single-bit full reduction over all DEPTH*WIDTH input bits.
- Sits between the gate-test stimulus logic and any consumer needing wide N-input gate results without a flat gate tree.

Parameters:
- WIDTH, 4, bits per operand word (>=1).
- DEPTH, 4, operand words per reduction (>=1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; discards any partial or held result.
- mode  in  2  operator: 00 AND, 01 OR, 10 XOR, 11 NAND; sampled on first beat only.
- in_valid  in  1  operand word present.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  operand word.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_data  out  WIDTH  bitwise fold of the DEPTH words.
- out_bit  out  1  reduction of all DEPTH*WIDTH bits.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, acc=0, cnt=0, mode_q=00, out_valid=0, out_data=0, out_bit=0. in_ready=1 once rst_n=1.
- States: IDLE, ACCUM, HOLD. in_ready=1 in IDLE and ACCUM, 0 in HOLD. A beat is accepted when in_valid & in_ready.
- IDLE, accepted beat: acc<=in_data, mode_q<=mode, cnt<=1. Goes to HOLD if DEPTH==1, else ACCUM.
- ACCUM, accepted beat: acc<=op(acc,in_data) per mode_q, cnt<=cnt+1. When cnt==DEPTH-1 at accept, goes to HOLD. Mode changes after the first beat are ignored.
- op per mode_q: AND/NAND use acc&in_data, OR uses acc|in_data, XOR uses acc^in_data.
- HOLD outputs (registered, visible the cycle after the last accept; latency 1):
  - out_valid=1.
  - out_data = ~acc for NAND, else acc.
  - out_bit = &acc (AND), ~&acc (NAND), |acc (OR), ^acc (XOR).
- HOLD with out_ready=1: next cycle state=IDLE, out_valid=0, cnt=0. out_data and out_bit keep their last values.
- HOLD with out_ready=0: state and outputs stable indefinitely.
- No input bypass in HOLD: an in_valid beat in the same cycle as the result handshake is not accepted.
- Minimum period is DEPTH+1 cycles per result.
- flush=1 in any state: next cycle state=IDLE, cnt=0, acc=0, out_valid=0. flush has priority over a simultaneous accept or handshake, and a beat presented in a flush cycle is dropped.
- rst_n low mid-operation: immediate return to the reset values. The partial result is lost and no out_valid is produced.
- cnt width is $clog2(DEPTH+1); the counter never wraps.
- in_valid=0 stalls in ACCUM with acc and cnt unchanged.

Decomposition:
- Shared package gate_pkg:
  - mode constants MODE_AND=2'b00, MODE_OR=2'b01, MODE_XOR=2'b10, MODE_NAND=2'b11.
  - state encoding IDLE/ACCUM/HOLD.
- One combinational sub-module, reduce_op_cell (a, b, mode -> y, WIDTH-parametrised), instantiated once for the fold.
- Output reduction stays inline in seq_reduce_gate.

Test Plan:
- WIDTH=1, DEPTH=4, AND mode: sweep all 16 patterns of a,b,c,d, one bit per beat. out_bit=1 only for 1,1,1,1, and out_valid rises 1 cycle after the 4th accept.
- WIDTH=4, DEPTH=2, XOR: words 4'b1010 then 4'b0110 -> out_data=4'b1100, out_bit=0. NAND with 4'hF, 4'hF -> out_data=4'h0, out_bit=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD. out_valid and out_data stay stable, in_ready=0, and extra in_valid beats are not consumed.
- Mode switch: mode=OR on beat 1, then mode=AND on beats 2-4 with data 0001,0000,0000,0000 (WIDTH=4). Result uses OR: out_data=4'b0001, out_bit=1.
- Flush after 2 of 4 beats, then a fresh 4-beat AND of all 4'hF -> out_data=4'hF, out_bit=1, with no stale bits from the flushed data.
- Assert rst_n low asynchronously mid-ACCUM and in HOLD. Outputs are 0 immediately, in_ready=1 after release, and the next reduction is correct.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared operator codes and state encoding for the sequential reduce gate.
package gate_pkg;

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_reduce_gate_if.sv
// Operand stream in, folded result out, plus flush/mode controls.
interface seq_reduce_gate_if #(
  parameter int WIDTH = 4
);
  logic             flush;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_bit;

  modport master (
    output flush, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_bit
  );

  modport slave (
    input  flush, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_bit
  );
endinterface

// File: rtl/reduce_op_cell.sv
// One bitwise fold step; NAND folds as AND, inversion is applied at the output.
module reduce_op_cell
  import gate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y
);

  // select the fold operator
  always_comb begin
    y = a & b;
    case (mode)
      MODE_OR:  y = a | b;
      MODE_XOR: y = a ^ b;
      default:  y = a & b;
    endcase
  end

endmodule

// File: rtl/seq_reduce_gate.sv
// Sequential N-input gate: folds DEPTH words of WIDTH bits, then holds the
// folded word and a single-bit reduction until the consumer takes it.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a reduction
//   ACCUM | folding beats 2..DEPTH
//   HOLD  | result valid, waiting for out_ready
module seq_reduce_gate
  import gate_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_reduce_gate_if.slave  bus
);

  localparam int          CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_mode_q;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_bit;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_fold;
  logic [WIDTH-1:0] w_acc_next;
  logic [1:0]       w_mode_eff;
  logic [WIDTH-1:0] w_res_data;
  logic             w_res_bit;

  assign w_in_ready = (r_state != HOLD);
  assign w_accept   = bus.in_valid & w_in_ready;
  // the first beat carries its own mode; later beats use the latched one
  assign w_mode_eff = (r_state == IDLE) ? bus.mode    : r_mode_q;
  assign w_acc_next = (r_state == IDLE) ? bus.in_data : w_fold;
  assign w_last     = w_accept &&
                      ((r_state == IDLE) ? (DEPTH == 1) : (r_cnt == LAST));

  reduce_op_cell #(.WIDTH(WIDTH)) u_op (
    .a    (r_acc),
    .b    (bus.in_data),
    .mode (r_mode_q),
    .y    (w_fold)
  );

  // result word and full reduction of the value about to be held
  always_comb begin
    w_res_data = w_acc_next;
    w_res_bit  = &w_acc_next;
    case (w_mode_eff)
      MODE_OR:   w_res_bit = |w_acc_next;
      MODE_XOR:  w_res_bit = ^w_acc_next;
      MODE_NAND: begin
        w_res_data = ~w_acc_next;
        w_res_bit  = ~&w_acc_next;
      end
      default:   w_res_bit = &w_acc_next;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic; flush wins over accept and handshake
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = w_last ? HOLD : ACCUM;
        ACCUM:   if (w_last) w_state_nxt = HOLD;
        HOLD:    if (bus.out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // accumulator, beat counter, latched mode and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mode_q    <= MODE_AND;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bit   <= 1'b0;
    end else if (bus.flush) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_acc_next;
        if (r_state == IDLE) begin
          r_mode_q <= bus.mode;
          r_cnt    <= CW'(1);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res_data;
        r_out_bit   <= w_res_bit;
      end else if (r_state == HOLD && bus.out_ready) begin
        r_out_valid <= 1'b0;
        r_cnt       <= '0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_bit   = r_out_bit;

endmodule

// File: tb/tb_seq_reduce_gate.sv
// Directed bench for seq_reduce_gate in three shapes: 1x4, 4x2 and 4x4.
module tb_seq_reduce_gate;
  import gate_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  seq_reduce_gate_if #(.WIDTH(1)) ifc1 ();
  seq_reduce_gate_if #(.WIDTH(4)) ifc2 ();
  seq_reduce_gate_if #(.WIDTH(4)) ifc4 ();

  seq_reduce_gate #(.WIDTH(1), .DEPTH(4)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
  seq_reduce_gate #(.WIDTH(4), .DEPTH(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(ifc2.slave));
  seq_reduce_gate #(.WIDTH(4), .DEPTH(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(ifc4.slave));

  typedef struct {
    logic [3:0][1:0] modes;
    logic [3:0][3:0] w;
    logic [3:0]      exp_data;
    logic            exp_bit;
  } vec_t;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] w0;
    logic [3:0] w1;
    logic [3:0] exp_data;
    logic       exp_bit;
  } vec2_t;

  typedef struct {
    logic [3:0] bits;
    logic       exp_bit;
  } vec1_t;

  vec_t  t4[6];
  vec2_t t2[2];
  vec1_t t1[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat1(input logic d);
    ifc1.in_valid = 1'b1; ifc1.in_data = d; ifc1.mode = MODE_AND;
    cyc();
    ifc1.in_valid = 1'b0;
  endtask

  task automatic beat2(input logic [1:0] m, input logic [3:0] d);
    ifc2.in_valid = 1'b1; ifc2.in_data = d; ifc2.mode = m;
    cyc();
    ifc2.in_valid = 1'b0;
  endtask

  task automatic beat4(input logic [1:0] m, input logic [3:0] d);
    ifc4.in_valid = 1'b1; ifc4.in_data = d; ifc4.mode = m;
    cyc();
    ifc4.in_valid = 1'b0;
  endtask

  task automatic ack1(input string nm);
    ifc1.out_ready = 1'b1; cyc(); ifc1.out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 32'(ifc1.out_valid), 32'd0);
  endtask

  task automatic ack2(input string nm);
    ifc2.out_ready = 1'b1; cyc(); ifc2.out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 32'(ifc2.out_valid), 32'd0);
  endtask

  task automatic ack4(input string nm);
    ifc4.out_ready = 1'b1; cyc(); ifc4.out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 32'(ifc4.out_valid), 32'd0);
    chk({nm, "_ready_back"}, 32'(ifc4.in_ready), 32'd1);
  endtask

  task automatic run4(input vec_t v, input string nm);
    for (int k = 3; k >= 0; k--) begin
      beat4(v.modes[k], v.w[k]);
      if (k == 1) chk({nm, "_early_valid"}, 32'(ifc4.out_valid), 32'd0);
    end
    chk({nm, "_valid"}, 32'(ifc4.out_valid), 32'd1);
    chk({nm, "_data"},  32'(ifc4.out_data),  32'(v.exp_data));
    chk({nm, "_bit"},   32'(ifc4.out_bit),   32'(v.exp_bit));
  endtask

  initial begin
    vec_t v;

    // 4x4 table; modes/w listed beat1..beat4 from the msb slot down
    t4[0] = '{modes: {MODE_AND, MODE_AND, MODE_AND, MODE_AND},
              w: {4'hF, 4'hF, 4'hF, 4'hF}, exp_data: 4'hF, exp_bit: 1'b1};
    t4[1] = '{modes: {MODE_OR, MODE_AND, MODE_AND, MODE_AND},
              w: {4'h1, 4'h0, 4'h0, 4'h0}, exp_data: 4'h1, exp_bit: 1'b1};
    t4[2] = '{modes: {MODE_XOR, MODE_XOR, MODE_XOR, MODE_XOR},
              w: {4'h1, 4'h2, 4'h4, 4'h8}, exp_data: 4'hF, exp_bit: 1'b0};
    t4[3] = '{modes: {MODE_NAND, MODE_NAND, MODE_NAND, MODE_NAND},
              w: {4'hF, 4'hF, 4'hF, 4'hE}, exp_data: 4'h1, exp_bit: 1'b1};
    t4[4] = '{modes: {MODE_OR, MODE_OR, MODE_OR, MODE_OR},
              w: {4'h0, 4'h0, 4'h0, 4'h0}, exp_data: 4'h0, exp_bit: 1'b0};
    t4[5] = '{modes: {MODE_XOR, MODE_OR, MODE_AND, MODE_NAND},
              w: {4'h7, 4'h0, 4'h0, 4'h0}, exp_data: 4'h7, exp_bit: 1'b1};
    t2[0] = '{mode: MODE_XOR,  w0: 4'b1010, w1: 4'b0110, exp_data: 4'b1100, exp_bit: 1'b0};
    t2[1] = '{mode: MODE_NAND, w0: 4'hF,    w1: 4'hF,    exp_data: 4'h0,    exp_bit: 1'b0};
    for (int i = 0; i < 16; i++) begin
      t1[i].bits    = 4'(i);
      t1[i].exp_bit = (i == 15);
    end

    ifc1.flush = 0; ifc1.mode = 0; ifc1.in_valid = 0; ifc1.in_data = 0; ifc1.out_ready = 0;
    ifc2.flush = 0; ifc2.mode = 0; ifc2.in_valid = 0; ifc2.in_data = 0; ifc2.out_ready = 0;
    ifc4.flush = 0; ifc4.mode = 0; ifc4.in_valid = 0; ifc4.in_data = 0; ifc4.out_ready = 0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(ifc4.out_valid), 32'd0);
    chk("rst_data",  32'(ifc4.out_data),  32'd0);
    chk("rst_bit",   32'(ifc4.out_bit),   32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rst_ready1", 32'(ifc1.in_ready), 32'd1);
    chk("rst_ready4", 32'(ifc4.in_ready), 32'd1);

    // 1-bit, 4-deep AND sweep
    for (int i = 0; i < 16; i++) begin
      for (int k = 3; k >= 0; k--) begin
        beat1(t1[i].bits[k]);
        if (k == 1) chk("sweep_early_valid", 32'(ifc1.out_valid), 32'd0);
      end
      chk($sformatf("sweep%0d_valid", i), 32'(ifc1.out_valid), 32'd1);
      chk($sformatf("sweep%0d_bit", i),   32'(ifc1.out_bit),   32'(t1[i].exp_bit));
      chk($sformatf("sweep%0d_data", i),  32'(ifc1.out_data),  32'(t1[i].exp_bit));
      ack1($sformatf("sweep%0d", i));
    end

    // 4-bit, 2-deep
    for (int i = 0; i < 2; i++) begin
      beat2(t2[i].mode, t2[i].w0);
      chk($sformatf("d2_%0d_early_valid", i), 32'(ifc2.out_valid), 32'd0);
      beat2(t2[i].mode, t2[i].w1);
      chk($sformatf("d2_%0d_valid", i), 32'(ifc2.out_valid), 32'd1);
      chk($sformatf("d2_%0d_data", i),  32'(ifc2.out_data),  32'(t2[i].exp_data));
      chk($sformatf("d2_%0d_bit", i),   32'(ifc2.out_bit),   32'(t2[i].exp_bit));
      ack2($sformatf("d2_%0d", i));
    end

    // 4-bit, 4-deep table, including the mode-switch case
    for (int i = 0; i < 6; i++) begin
      run4(t4[i], $sformatf("d4_%0d", i));
      ack4($sformatf("d4_%0d", i));
    end

    // backpressure: result held, zero beats offered and refused
    beat4(MODE_AND, 4'h5); beat4(MODE_AND, 4'h7); beat4(MODE_AND, 4'hF); beat4(MODE_AND, 4'hD);
    ifc4.in_valid = 1'b1; ifc4.in_data = 4'h0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), 32'(ifc4.out_valid), 32'd1);
      chk($sformatf("bp%0d_data", c),  32'(ifc4.out_data),  32'h5);
      chk($sformatf("bp%0d_bit", c),   32'(ifc4.out_bit),   32'd0);
      chk($sformatf("bp%0d_ready", c), 32'(ifc4.in_ready),  32'd0);
      cyc();
    end
    ifc4.out_ready = 1'b1;
    cyc();
    ifc4.out_ready = 1'b0; ifc4.in_valid = 1'b0;
    chk("bp_release_valid", 32'(ifc4.out_valid), 32'd0);
    chk("bp_keep_data",     32'(ifc4.out_data),  32'h5);
    run4(t4[0], "bp_after");
    ack4("bp_after");

    // flush after two beats, beat in the flush cycle dropped
    beat4(MODE_OR, 4'h3); beat4(MODE_OR, 4'h0);
    ifc4.flush = 1'b1; ifc4.in_valid = 1'b1; ifc4.in_data = 4'h0; ifc4.mode = MODE_OR;
    cyc();
    ifc4.flush = 1'b0; ifc4.in_valid = 1'b0;
    chk("flush_valid", 32'(ifc4.out_valid), 32'd0);
    run4(t4[0], "post_flush");

    // flush while holding a result
    ifc4.flush = 1'b1; ifc4.out_ready = 1'b0;
    cyc();
    ifc4.flush = 1'b0;
    chk("flush_hold_valid", 32'(ifc4.out_valid), 32'd0);
    chk("flush_hold_ready", 32'(ifc4.in_ready),  32'd1);
    v = '{modes: {MODE_XOR, MODE_XOR, MODE_XOR, MODE_XOR},
          w: {4'hC, 4'h0, 4'h0, 4'h0}, exp_data: 4'hC, exp_bit: 1'b0};
    run4(v, "post_flush_hold");
    ack4("post_flush_hold");

    // async reset mid-ACCUM (out_data currently 4'hC)
    beat4(MODE_AND, 4'hF); beat4(MODE_AND, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_accum_data", 32'(ifc4.out_data), 32'd0);
    chk("arst_accum_valid", 32'(ifc4.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_accum_ready", 32'(ifc4.in_ready), 32'd1);
    run4(t4[3], "post_arst_accum");

    // async reset in HOLD
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hold_valid", 32'(ifc4.out_valid), 32'd0);
    chk("arst_hold_data",  32'(ifc4.out_data),  32'd0);
    chk("arst_hold_bit",   32'(ifc4.out_bit),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_hold_ready", 32'(ifc4.in_ready), 32'd1);
    run4(t4[2], "post_arst_hold");
    ack4("post_arst_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
